// File: rtl/frame_pkg.sv
// Shared definitions for the frame transmit controller:
// header layout, fixed header constants and FSM states.
package frame_pkg;

    localparam logic [7:0]  SYNC0     = 8'hFA;
    localparam logic [7:0]  SYNC1     = 8'hF3;
    localparam logic [15:0] ETHERTYPE = 16'h88B5;

    localparam int HDR_LEN  = 20;
    localparam int OFF_DST  = 0;
    localparam int OFF_SRC  = 6;
    localparam int OFF_TYPE = 12;
    localparam int OFF_SYNC = 14;
    localparam int OFF_ID   = 16;
    localparam int OFF_SEQ  = 17;
    localparam int OFF_LEN  = 18;
    localparam int OFF_PAY  = HDR_LEN;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    function automatic int frame_len(int nregs);
        return HDR_LEN + 4 * nregs;
    endfunction

endpackage

// File: rtl/frame_tx_ctrl_rr_arb.sv
// Combinational round-robin picker: the search starts one
// position after the previous winner and wraps around.
module rr_arb
    import frame_pkg::*;
#(
    parameter int Nreq = 2,
    parameter int LW   = (Nreq > 1) ? $clog2(Nreq) : 1
) (
    input  logic [Nreq-1:0] pending,
    input  logic [LW-1:0]   last_grant,
    output logic [Nreq-1:0] grant
);

    int best;
    int sel;
    int rank;

    // rank 0 is the index right after last_grant
    always_comb begin
        best = Nreq;
        sel  = 0;
        rank = 0;
        for (int i = 0; i < Nreq; i++) begin
            rank = (i + Nreq - 1 - int'(last_grant)) % Nreq;
            if (pending[i] && rank < best) begin
                best = rank;
                sel  = i;
            end
        end
        grant = '0;
        for (int i = 0; i < Nreq; i++) begin
            grant[i] = (best < Nreq) && (sel == i);
        end
    end

endmodule

// File: rtl/frame_tx_ctrl.sv
// Arbitrates frame requests, snapshots the register bank and
// streams one header+payload frame per grant to the MAC FIFO.
module frame_tx_ctrl
    import frame_pkg::*;
#(
    parameter int          Nregs   = 16,
    parameter int          Nreq    = 2,
    parameter int          Ngap    = 12,
    parameter logic [47:0] DST_MAC = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC = 48'h0200_0000_0001
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [Nreq-1:0]        req,
    output logic [Nreq-1:0]        grant,
    output logic [Nreq-1:0]        req_drop,
    input  logic [Nregs-1:0][31:0] rd_val,
    output logic                   busy,
    output logic                   tx_fifo_tvalid,
    input  logic                   tx_fifo_tready,
    output logic [7:0]             tx_fifo_tdata,
    output logic                   tx_fifo_tlast
);

    localparam int          FLEN = frame_len(Nregs);
    localparam int          CW   = $clog2(FLEN);
    localparam int          LW   = (Nreq > 1) ? $clog2(Nreq) : 1;
    localparam int          GW   = (Ngap > 1) ? $clog2(Ngap) : 1;
    localparam logic [15:0] PLEN = 16'(4 * Nregs);

    state_t               state;
    state_t               state_n;
    logic [Nreq-1:0]      pending;
    logic [Nreq-1:0]      arb_gnt;
    logic [LW-1:0]        last_grant;
    logic [LW-1:0]        gnt_idx;
    logic [7:0]           seq;
    logic [7:0]           seq_q;
    logic [7:0]           id_q;
    logic [CW-1:0]        cnt;
    logic [GW-1:0]        gap_cnt;
    logic [Nregs*32-1:0]  snap;
    logic                 start;
    logic                 fire;
    logic                 last_byte;
    logic [CW-1:0]        didx;
    logic [CW-1:0]        sidx;
    logic [CW-1:0]        pidx;
    logic [7:0]           dst_b;
    logic [7:0]           src_b;
    logic [7:0]           pay_b;
    logic [7:0]           byte_nx;

    rr_arb #(
        .Nreq (Nreq),
        .LW   (LW)
    ) u_arb (
        .pending    (pending),
        .last_grant (last_grant),
        .grant      (arb_gnt)
    );

    assign grant     = (state == IDLE) ? arb_gnt : '0;
    assign start     = (state == IDLE) && (|pending);
    assign req_drop  = req & pending & ~grant;
    assign busy      = (state != IDLE) || start;
    assign fire      = tx_fifo_tvalid && tx_fifo_tready;
    assign last_byte = (cnt == CW'(FLEN - 1));

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < Nreq; i++) begin
            if (grant[i]) gnt_idx = LW'(i);
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (|pending) state_n = SEND;
            SEND: if (fire && last_byte) state_n = GAP;
            GAP:  if (gap_cnt == GW'(Ngap - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // MACs go out MSB first, payload registers LSB first
    assign didx  = CW'(OFF_DST + 5) - cnt;
    assign sidx  = CW'(OFF_SRC + 5) - cnt;
    assign pidx  = cnt - CW'(OFF_PAY);
    assign dst_b = 8'(DST_MAC >> {didx, 3'b000});
    assign src_b = 8'(SRC_MAC >> {sidx, 3'b000});
    assign pay_b = 8'(snap >> {pidx, 3'b000});

    always_comb begin
        byte_nx = pay_b;
        if (int'(cnt) < OFF_SRC) begin
            byte_nx = dst_b;
        end else if (int'(cnt) < OFF_TYPE) begin
            byte_nx = src_b;
        end else if (int'(cnt) < OFF_PAY) begin
            unique case (1'b1)
                int'(cnt) == OFF_TYPE:     byte_nx = ETHERTYPE[15:8];
                int'(cnt) == OFF_TYPE + 1: byte_nx = ETHERTYPE[7:0];
                int'(cnt) == OFF_SYNC:     byte_nx = SYNC0;
                int'(cnt) == OFF_SYNC + 1: byte_nx = SYNC1;
                int'(cnt) == OFF_ID:       byte_nx = id_q;
                int'(cnt) == OFF_SEQ:      byte_nx = seq_q;
                int'(cnt) == OFF_LEN:      byte_nx = PLEN[7:0];
                default:                   byte_nx = PLEN[15:8];
            endcase
        end
    end

    assign tx_fifo_tvalid = (state == SEND);
    assign tx_fifo_tlast  = (state == SEND) && last_byte;
    assign tx_fifo_tdata  = (state == SEND) ? byte_nx : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            last_grant <= LW'(Nreq - 1);
            seq        <= '0;
            seq_q      <= '0;
            id_q       <= '0;
            cnt        <= '0;
            gap_cnt    <= '0;
            snap       <= '0;
        end else begin
            state   <= state_n;
            pending <= (pending & ~grant) | req;
            if (start) begin
                last_grant <= gnt_idx;
                id_q       <= 8'(gnt_idx);
                seq_q      <= seq;
                snap       <= rd_val;
                cnt        <= '0;
            end
            if (fire) begin
                if (last_byte) begin
                    cnt <= '0;
                    seq <= seq + 8'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
        end
    end

endmodule

// File: tb/tb_frame_tx_ctrl.sv
// Bench for frame_tx_ctrl: directed corner sequences, a byte
// table and a randomized run against a frame-level model.
module tb_frame_tx_ctrl;

    localparam int          NREGS = 16;
    localparam int          NREQ  = 2;
    localparam int          NGAP  = 12;
    localparam int          FLEN  = 20 + 4 * NREGS;
    localparam logic [47:0] DST   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC   = 48'h0200_0000_0001;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        req_drop;
    logic [NREGS-1:0][31:0] rd_val;
    logic                   busy;
    logic                   tvalid;
    logic                   tready;
    logic [7:0]             tdata;
    logic                   tlast;

    frame_tx_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .grant          (grant),
        .req_drop       (req_drop),
        .rd_val         (rd_val),
        .busy           (busy),
        .tx_fifo_tvalid (tvalid),
        .tx_fifo_tready (tready),
        .tx_fifo_tdata  (tdata),
        .tx_fifo_tlast  (tlast)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [8:0]      exp_q[$];
    logic [7:0]      cap_q[$];
    logic            cap_last[$];
    logic [7:0]      id_seen[$];
    logic [7:0]      seq_seen[$];
    int              nframes;
    int              cur_off;
    int              cyc = 0;
    int              tlast_cyc = -100000;
    int              last_gap = -1;
    int              drop_cnt[NREQ];
    logic [NREQ-1:0] m_pend = '0;
    int              m_last = NREQ - 1;
    logic [7:0]      m_seq = '0;
    bit              in_frame = 0;
    bit              prev_stall = 0;
    logic [7:0]      prev_data;
    logic            prev_last;

    function automatic int rr_pick(input logic [NREQ-1:0] p, input int last);
        for (int o = 1; o <= NREQ; o++) begin
            if (((p >> ((last + o) % NREQ)) & 1) != 0) return (last + o) % NREQ;
        end
        return -1;
    endfunction

    task automatic push_frame(input int id, input logic [7:0] sq,
                              input logic [NREGS*32-1:0] regs);
        logic [7:0] b;
        int k, j;
        for (int off = 0; off < FLEN; off++) begin
            if (off < 6) b = 8'(DST >> (8 * (5 - off)));
            else if (off < 12) b = 8'(SRC >> (8 * (11 - off)));
            else if (off == 12) b = 8'h88;
            else if (off == 13) b = 8'hB5;
            else if (off == 14) b = 8'hFA;
            else if (off == 15) b = 8'hF3;
            else if (off == 16) b = 8'(id);
            else if (off == 17) b = sq;
            else if (off == 18) b = 8'((4 * NREGS) % 256);
            else if (off == 19) b = 8'((4 * NREGS) / 256);
            else begin
                k = (off - 20) / 4;
                j = (off - 20) % 4;
                b = 8'(regs >> (32 * k + 8 * j));
            end
            exp_q.push_back({off == FLEN - 1, b});
        end
    endtask

    always @(negedge clk) begin
        int e;
        logic [NREQ-1:0] eg;
        logic [8:0] x;
        cyc++;
        if (reset) begin
            exp_q.delete();
            m_pend     = '0;
            m_last     = NREQ - 1;
            m_seq      = '0;
            in_frame   = 0;
            prev_stall = 0;
            cur_off    = 0;
            tlast_cyc  = -100000;
        end else begin
            chk("tvalid_window", tvalid, in_frame);
            if (prev_stall) begin
                chk("hold_tdata", tdata, prev_data);
                chk("hold_tlast", tlast, prev_last);
            end
            e  = rr_pick(m_pend, m_last);
            eg = (e < 0) ? '0 : NREQ'(1) << e;
            if (!in_frame && (cyc - tlast_cyc > NGAP)) chk("grant", grant, eg);
            else chk("grant_while_busy", grant, '0);
            if (grant != '0 && e >= 0) begin
                if (tlast_cyc > 0) last_gap = cyc - tlast_cyc - 1;
                m_last = e;
                push_frame(e, m_seq, rd_val);
                in_frame = 1;
            end
            chk("req_drop", req_drop, req & m_pend & ~grant);
            for (int i = 0; i < NREQ; i++) drop_cnt[i] += int'(req_drop[i]);
            m_pend = (m_pend & ~grant) | req;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    chk("tdata", tdata, x[7:0]);
                    chk("tlast", tlast, x[8]);
                    cap_q.push_back(tdata);
                    cap_last.push_back(tlast);
                    if (cur_off == 16) id_seen.push_back(tdata);
                    if (cur_off == 17) seq_seen.push_back(tdata);
                    cur_off++;
                    if (x[8]) begin
                        nframes++;
                        cur_off   = 0;
                        in_frame  = 0;
                        tlast_cyc = cyc;
                        m_seq     = m_seq + 8'd1;
                    end
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < NREGS; k++)
            rd_val[k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req    = '0;
        tready = 1'b1;
        cap_q.delete();
        cap_last.delete();
        id_seen.delete();
        seq_seen.delete();
        nframes = 0;
        for (int i = 0; i < NREQ; i++) drop_cnt[i] = 0;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (nframes < n && t < budget) begin
            step();
            t++;
        end
        chk("frames_done_in_time", nframes >= n, 1);
    endtask

    typedef struct {
        string      name;
        int         off;
        logic [7:0] val;
    } vec_t;

    vec_t       tbl[16];
    logic [7:0] ref_frame[$];
    int         diffs;
    int         nl;

    initial begin
        tbl[0]  = '{"dst_b0",   0, 8'hFF};
        tbl[1]  = '{"dst_b5",   5, 8'hFF};
        tbl[2]  = '{"src_b6",   6, 8'h02};
        tbl[3]  = '{"src_b7",   7, 8'h00};
        tbl[4]  = '{"src_b11", 11, 8'h01};
        tbl[5]  = '{"etype_hi",12, 8'h88};
        tbl[6]  = '{"etype_lo",13, 8'hB5};
        tbl[7]  = '{"sync0",   14, 8'hFA};
        tbl[8]  = '{"sync1",   15, 8'hF3};
        tbl[9]  = '{"req_id",  16, 8'h00};
        tbl[10] = '{"seq",     17, 8'h00};
        tbl[11] = '{"len_lo",  18, 8'h40};
        tbl[12] = '{"len_hi",  19, 8'h00};
        tbl[13] = '{"pay_20",  20, 8'h00};
        tbl[14] = '{"pay_50",  50, 8'h1E};
        tbl[15] = '{"pay_83",  83, 8'h3F};

        reset  = 1'b1;
        req    = '0;
        tready = 1'b1;
        set_ramp();
        step();
        step();
        chk("rst_grant", grant, '0);
        chk("rst_req_drop", req_drop, '0);
        chk("rst_busy", busy, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 8'h00);

        // single request, free-flowing sink
        do_reset();
        req = 2'b01;
        step();
        req = '0;
        chk("grant_at_plus1", grant, 2'b01);
        chk("busy_at_grant", busy, 1);
        step();
        chk("tvalid_after_grant", tvalid, 1);
        chk("grant_one_cycle", grant, '0);
        wait_frames(1, 300);
        chk("frame_len", cap_q.size(), FLEN);
        nl = 0;
        foreach (cap_last[i]) nl += int'(cap_last[i]);
        chk("tlast_count", nl, 1);
        if (cap_q.size() == FLEN) begin
            chk("tlast_on_83", cap_last[FLEN-1], 1);
            for (int i = 0; i < 16; i++)
                chk(tbl[i].name, cap_q[tbl[i].off], tbl[i].val);
        end
        ref_frame = cap_q;

        // simultaneous requests: id 0 then id 1, gap between
        do_reset();
        req = 2'b11;
        step();
        req = '0;
        wait_frames(2, 500);
        chk("dual_id0", id_seen.size() > 0 ? id_seen[0] : 8'hEE, 8'h00);
        chk("dual_id1", id_seen.size() > 1 ? id_seen[1] : 8'hEE, 8'h01);
        chk("dual_seq0", seq_seen.size() > 0 ? seq_seen[0] : 8'hEE, 8'h00);
        chk("dual_seq1", seq_seen.size() > 1 ? seq_seen[1] : 8'hEE, 8'h01);
        chk("dual_gap", last_gap, NGAP);

        // random back-pressure must not alter the byte stream
        do_reset();
        set_ramp();
        req = 2'b01;
        step();
        req = '0;
        for (int c = 0; c < 2000 && nframes < 1; c++) begin
            tready = 1'($urandom_range(0, 1));
            step();
        end
        tready = 1'b1;
        chk("stall_frame_done", nframes, 1);
        chk("stall_len", cap_q.size(), ref_frame.size());
        diffs = 0;
        for (int i = 0; i < cap_q.size() && i < ref_frame.size(); i++)
            if (cap_q[i] !== ref_frame[i]) diffs++;
        chk("stall_stream_eq", diffs, 0);

        // payload comes from the snapshot, not live rd_val
        do_reset();
        set_ramp();
        rd_val[0] = 32'h1122_3344;
        req = 2'b01;
        step();
        req = '0;
        step();
        rd_val = '0;
        wait_frames(1, 300);
        if (cap_q.size() >= 24) begin
            chk("snap_b20", cap_q[20], 8'h44);
            chk("snap_b21", cap_q[21], 8'h33);
            chk("snap_b22", cap_q[22], 8'h22);
            chk("snap_b23", cap_q[23], 8'h11);
        end else begin
            chk("snap_len", cap_q.size(), FLEN);
        end
        set_ramp();

        // coalesced request while pending
        do_reset();
        req = 2'b01;
        step();
        req = '0;
        repeat (5) step();
        req = 2'b10;
        step();
        req = '0;
        repeat (5) step();
        req = 2'b10;
        step();
        req = '0;
        wait_frames(2, 500);
        repeat (200) step();
        chk("drop_count_1", drop_cnt[1], 1);
        chk("drop_count_0", drop_cnt[0], 0);
        chk("coalesced_frames", nframes, 2);

        // sequence number wraps after 256 frames
        do_reset();
        req = 2'b01;
        wait_frames(257, 257 * 100);
        req = '0;
        for (int c = 0; c < 300 && busy; c++) step();
        chk("seq_255", seq_seen.size() > 255 ? seq_seen[255] : 8'hEE, 8'hFF);
        chk("seq_wrap", seq_seen.size() > 256 ? seq_seen[256] : 8'hEE, 8'h00);

        // reset in the middle of a frame
        do_reset();
        req = 2'b01;
        step();
        req = '0;
        for (int c = 0; c < 200 && cur_off < 40; c++) step();
        chk("reached_byte40", cur_off, 40);
        reset = 1'b1;
        step();
        chk("midrst_tvalid", tvalid, 0);
        chk("midrst_tlast", tlast, 0);
        chk("midrst_busy", busy, 0);
        reset = 1'b0;
        cap_q.delete();
        cap_last.delete();
        nframes = 0;
        req = 2'b01;
        step();
        req = '0;
        wait_frames(1, 300);
        chk("restart_len", cap_q.size(), FLEN);
        chk("restart_b0", cap_q.size() > 0 ? cap_q[0] : 8'hEE, 8'hFF);
        chk("restart_seq", cap_q.size() > 17 ? cap_q[17] : 8'hEE, 8'h00);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req    = ($urandom_range(0, 9) == 0) ? NREQ'($urandom) : '0;
            tready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NREGS; k++) rd_val[k] = $urandom;
            step();
        end
        req    = '0;
        tready = 1'b1;
        for (int c = 0; c < 1000 && (busy || exp_q.size() != 0); c++) step();
        chk("rand_drain_q", exp_q.size(), 0);
        chk("rand_idle", busy, 0);
        chk("rand_some_frames", nframes > 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/frame_tx_ctrl.md
FRAME_TX_CTRL -- requirements
Module: frame_tx_ctrl

Interface
REQ-001 SHALL have parameter Nregs, default 16, number of 32-bit registers carried in each frame payload.
REQ-002 SHALL have parameter Nreq, default 2, number of frame requesters.
REQ-003 SHALL have parameter Ngap, default 12, idle cycles inserted after each frame.
REQ-004 SHALL have parameters DST_MAC and SRC_MAC, 48 bits each, defaults 48'hFFFF_FFFF_FFFF and 48'h0200_0000_0001.
REQ-005 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-006 SHALL have ports: req  in  Nreq  one-cycle request pulses; grant  out  Nreq  one-hot grant pulse; req_drop  out  Nreq  pulse when a request hits an already-pending bit.
REQ-007 SHALL have ports: rd_val  in  Nregs x 32  register values to snapshot; busy  out  1  high from grant through end of gap.
REQ-008 SHALL have ports: tx_fifo_tvalid  out  1; tx_fifo_tready  in  1; tx_fifo_tdata  out  8; tx_fifo_tlast  out  1 (AXI-stream byte stream to the tx MAC FIFO).

Function
REQ-009 SHALL set pending[i] on the clock edge after req[i]=1; pending[i] cleared when grant[i] pulses, unless req[i]=1 in that same cycle, in which case pending[i] stays set.
REQ-010 SHALL pulse req_drop[i] for one cycle when req[i]=1 while pending[i]=1 and grant[i]=0; the request is coalesced.
REQ-011 SHALL use states IDLE, SEND, GAP; IDLE -> SEND when any pending bit is set; SEND -> GAP on the accepted tlast byte; GAP -> IDLE after Ngap cycles.
REQ-012 SHALL pick the grant in IDLE by round-robin: search starts at index (last_grant+1) mod Nreq; last_grant resets to Nreq-1 so index 0 wins first.
REQ-013 SHALL, on the IDLE->SEND edge, pulse grant, snapshot rd_val, latch requester id and current sequence number; first tvalid appears the following cycle.
REQ-014 SHALL emit frame bytes in order: 0-5 DST_MAC MSB first; 6-11 SRC_MAC MSB first; 12-13 0x88, 0xB5; 14 0xFA; 15 0xF3; 16 requester id; 17 sequence number; 18-19 payload byte count, LSB first.
REQ-015 SHALL emit payload bytes from byte 20: register k byte j (bits 8j+7:8j) at offset 20+4k+j, total frame length 20+4*Nregs bytes.
REQ-016 SHALL assert tlast only on the final byte (offset 19+4*Nregs).
REQ-017 SHALL advance the byte counter only when tvalid and tready are both 1; tdata, tlast, tvalid held stable while tready=0.
REQ-018 SHALL keep tvalid high for every cycle of SEND and low in IDLE and GAP.
REQ-019 SHALL increment the 8-bit sequence number after each completed frame, wrapping 255->0.
REQ-020 SHALL size the byte counter as $clog2(20+4*Nregs) bits; no overflow beyond the final byte.
REQ-021 SHALL ignore rd_val changes after the snapshot until the next grant.

Reset
REQ-022 SHALL on reset: state IDLE, pending 0, last_grant Nreq-1, sequence 0, byte counter 0, grant 0, req_drop 0, busy 0, tvalid 0, tlast 0, tdata 0.
REQ-023 SHALL on reset mid-frame drop tvalid on the next edge with no tlast; the truncated frame is discarded downstream.

Structure
REQ-024 SHALL take from shared package frame_pkg: sync bytes 0xFA/0xF3, ethertype 0x88B5, header length 20, header byte offsets, state enum.
REQ-025 SHALL place round-robin selection in sub-module rr_arb (inputs pending, last_grant; output one-hot grant, combinational).

Verification
REQ-026 SHALL test single req[0] with tready=1 -> grant[0] at cycle +1, 84 bytes, byte14=0xFA, byte15=0xF3, byte16=0, byte17=0, bytes18-19=0x40,0x00, tlast on byte 83.
REQ-027 SHALL test req[0] and req[1] in the same cycle -> frames with id 0 then id 1; Ngap idle cycles between them; sequence 0 then 1.
REQ-028 SHALL test random tready toggling -> byte stream identical to tready=1 case; no tdata change while tvalid=1 and tready=0.
REQ-029 SHALL test rd_val[0]=0x11223344, changed to 0 after grant -> payload bytes 20-23 = 0x44,0x33,0x22,0x11.
REQ-030 SHALL test req[1] twice while pending -> one req_drop[1] pulse, one frame; 256 frames -> sequence wraps to 0; reset at byte 40 -> tvalid 0 next cycle, next frame starts at byte 0.
